// File: rtl/agc_servo.sv
// Closed-loop AGC servo: counts dsp gt/lt flags over a sample window and trims
// scale (RMS) and offset (DC), loading them through the dsp's two-stage coefficient path.
module agc_servo #(
  parameter int unsigned           WINDOW_LOG2  = 16,
  parameter int unsigned           TARGET_COUNT = 1024,
  parameter int unsigned           DEADBAND     = 64,
  parameter logic [16:0]           SCALE_INIT   = 17'h01000,
  parameter int unsigned           SCALE_STEP   = 16,
  parameter logic [16:0]           SCALE_MIN    = 17'h00100,
  parameter int unsigned           OFFSET_BITS  = 16,
  parameter int unsigned           OFFSET_STEP  = 16,
  parameter logic [OFFSET_BITS-1:0] OFFSET_LIMIT = 'h7F00
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   enable_i,
  input  logic                   valid_i,
  input  logic                   gt_i,
  input  logic                   lt_i,
  input  logic                   man_load_i,
  input  logic [16:0]            man_scale_i,
  input  logic [OFFSET_BITS-1:0] man_offset_i,
  output logic [16:0]            scale_o,
  output logic [OFFSET_BITS-1:0] offset_o,
  output logic                   ce_scale_o,
  output logic                   ce_offset_o,
  output logic                   apply_o,
  output logic                   dsp_en_o,
  output logic                   update_o
);

  localparam int unsigned CW = WINDOW_LOG2 + 1;
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(2**WINDOW_LOG2 - 1);
  localparam logic [16:0] SCALE_MAX = 17'h1FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_ACCUM,
    S_COMPUTE
  } state_e;

  state_e                 state_q;
  logic [16:0]            scale_q, scale_d;
  logic [OFFSET_BITS-1:0] offset_q, offset_d;
  logic [CW-1:0]          sample_cnt_q, gt_cnt_q, lt_cnt_q;
  logic                   ce_q, apply_q, dsp_en_q;

  logic [31:0] gt_w, lt_w, total_w, scale_w;
  int          off_w, off_n, lim;

  // Next coefficients from the finished window; only committed in COMPUTE.
  always_comb begin
    gt_w     = 32'(gt_cnt_q);
    lt_w     = 32'(lt_cnt_q);
    total_w  = gt_w + lt_w;
    scale_w  = 32'(scale_q);
    scale_d  = scale_q;
    off_w    = int'($signed(offset_q));
    lim      = int'(OFFSET_LIMIT);
    off_n    = off_w;

    if (total_w > TARGET_COUNT + DEADBAND) begin
      if (scale_w < 32'(SCALE_MIN) + SCALE_STEP) scale_d = SCALE_MIN;
      else                                       scale_d = 17'(scale_w - SCALE_STEP);
    end else if (total_w + DEADBAND < TARGET_COUNT) begin
      if (scale_w + SCALE_STEP > 32'(SCALE_MAX)) scale_d = SCALE_MAX;
      else                                       scale_d = 17'(scale_w + SCALE_STEP);
    end

    if (gt_w > lt_w + DEADBAND)      off_n = off_w - int'(OFFSET_STEP);
    else if (lt_w > gt_w + DEADBAND) off_n = off_w + int'(OFFSET_STEP);

    if (off_n > lim)       off_n = lim;
    else if (off_n < -lim) off_n = -lim;
    offset_d = OFFSET_BITS'(off_n);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      scale_q      <= SCALE_INIT;
      offset_q     <= '0;
      sample_cnt_q <= '0;
      gt_cnt_q     <= '0;
      lt_cnt_q     <= '0;
      ce_q         <= 1'b0;
      apply_q      <= 1'b0;
      dsp_en_q     <= 1'b0;
    end else begin
      ce_q    <= 1'b0;
      apply_q <= 1'b0;
      if (!enable_i) begin
        state_q      <= S_IDLE;
        sample_cnt_q <= '0;
        gt_cnt_q     <= '0;
        lt_cnt_q     <= '0;
      end else if (man_load_i) begin
        scale_q      <= man_scale_i;
        offset_q     <= man_offset_i;
        state_q      <= S_LOAD;
        ce_q         <= 1'b1;
        sample_cnt_q <= '0;
        gt_cnt_q     <= '0;
        lt_cnt_q     <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            state_q <= S_LOAD;
            ce_q    <= 1'b1;
          end
          S_LOAD: begin
            state_q <= S_APPLY;
            apply_q <= 1'b1;
          end
          S_APPLY: begin
            state_q      <= S_ACCUM;
            dsp_en_q     <= 1'b1;
            sample_cnt_q <= '0;
            gt_cnt_q     <= '0;
            lt_cnt_q     <= '0;
          end
          S_ACCUM: begin
            if (valid_i) begin
              sample_cnt_q <= sample_cnt_q + 1'b1;
              gt_cnt_q     <= gt_cnt_q + CW'(gt_i);
              lt_cnt_q     <= lt_cnt_q + CW'(lt_i);
              if (sample_cnt_q == LAST_SAMPLE) state_q <= S_COMPUTE;
            end
          end
          S_COMPUTE: begin
            scale_q  <= scale_d;
            offset_q <= offset_d;
            state_q  <= S_LOAD;
            ce_q     <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign scale_o     = scale_q;
  assign offset_o    = offset_q;
  assign ce_scale_o  = ce_q;
  assign ce_offset_o = ce_q;
  assign apply_o     = apply_q;
  assign update_o    = apply_q;
  assign dsp_en_o    = dsp_en_q;

endmodule

// File: tb/tb_agc_servo.sv
// Self-checking bench for agc_servo with a small window (16 samples, target 4, deadband 1).
module tb_agc_servo;

  logic        clk_i = 1'b0;
  logic        rstn_i, enable_i, valid_i, gt_i, lt_i, man_load_i;
  logic [16:0] man_scale_i;
  logic [15:0] man_offset_i;
  logic [16:0] scale_o;
  logic [15:0] offset_o;
  logic        ce_scale_o, ce_offset_o, apply_o, dsp_en_o, update_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [16:0] s;
    logic [15:0] o;
  } exp_t;
  exp_t sb[$];

  localparam int OLIM = 32'h7F00;
  int m_scale, m_off;

  always #5 clk_i = ~clk_i;

  agc_servo #(
    .WINDOW_LOG2 (4),
    .TARGET_COUNT(4),
    .DEADBAND    (1),
    .SCALE_STEP  (16),
    .OFFSET_STEP (16)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .enable_i    (enable_i),
    .valid_i     (valid_i),
    .gt_i        (gt_i),
    .lt_i        (lt_i),
    .man_load_i  (man_load_i),
    .man_scale_i (man_scale_i),
    .man_offset_i(man_offset_i),
    .scale_o     (scale_o),
    .offset_o    (offset_o),
    .ce_scale_o  (ce_scale_o),
    .ce_offset_o (ce_offset_o),
    .apply_o     (apply_o),
    .dsp_en_o    (dsp_en_o),
    .update_o    (update_o)
  );

  task automatic push_exp();
    sb.push_back({17'(m_scale), 16'(m_off)});
  endtask

  // Reference servo law for one completed window.
  task automatic model_window(input int g, input int l);
    int total;
    total = g + l;
    if (total > 5) begin
      m_scale = m_scale - 16;
      if (m_scale < 32'h100) m_scale = 32'h100;
    end else if (total < 3) begin
      m_scale = m_scale + 16;
      if (m_scale > 32'h1FFFF) m_scale = 32'h1FFFF;
    end
    if (g > l + 1)      m_off = m_off - 16;
    else if (l > g + 1) m_off = m_off + 16;
    if (m_off > OLIM)  m_off = OLIM;
    if (m_off < -OLIM) m_off = -OLIM;
    push_exp();
  endtask

  // Called at posedge+1; leaves valid low at posedge+1 after the last sample edge.
  task automatic feed(input int n, input int ngt, input int nlt, input bit gap);
    for (int i = 0; i < n; i++) begin
      valid_i = 1'b1;
      gt_i    = (i < ngt);
      lt_i    = (i < nlt);
      @(posedge clk_i); #1;
      if (gap && i < n - 1) begin
        valid_i = 1'b0;
        gt_i    = 1'b0;
        lt_i    = 1'b0;
        @(posedge clk_i); #1;
      end
    end
    valid_i = 1'b0;
    gt_i    = 1'b0;
    lt_i    = 1'b0;
  endtask

  // Waits (bounded) for apply_o, scoreboards the applied coefficients, ends at posedge+1.
  task automatic finish_update(input string tag, input int want_apply, input int want_ce,
                               output logic en_at_apply);
    int   na, nc;
    exp_t e;
    na = -1;
    nc = -1;
    en_at_apply = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      if (ce_scale_o && ce_offset_o) nc = k;
      if (apply_o) begin
        na = k;
        en_at_apply = dsp_en_o;
        break;
      end
    end
    checks++;
    if (na != want_apply) begin
      failures++;
      $display("FAIL %s_apply_latency got=%0d want=%0d", tag, na, want_apply);
    end
    if (want_ce > 0) begin
      checks++;
      if (nc != want_ce) begin
        failures++;
        $display("FAIL %s_ce_cycle got=%0d want=%0d", tag, nc, want_ce);
      end
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard_empty got=%h/%h want=none", tag, scale_o, offset_o);
    end else begin
      e = sb.pop_front();
      if ({scale_o, offset_o} !== e) begin
        failures++;
        $display("FAIL %s_coeffs scale/offset got=%h/%h want=%h/%h", tag, scale_o, offset_o, e.s, e.o);
      end
    end
    checks++;
    if (update_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_update got=%b want=1", tag, update_o);
    end
    @(posedge clk_i); #1;
  endtask

  // Called at posedge+1 with state ACCUM next; ends at posedge+1 after the apply.
  task automatic do_man_load(input string tag, input logic [16:0] s, input logic [15:0] o);
    logic en;
    man_scale_i  = s;
    man_offset_i = o;
    man_load_i   = 1'b1;
    m_scale = int'(s);
    m_off   = int'($signed(o));
    push_exp();
    @(posedge clk_i); #1;
    man_load_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (!(ce_scale_o && ce_offset_o) || scale_o !== s || offset_o !== o) begin
      failures++;
      $display("FAIL %s_load ce=%b scale/offset got=%h/%h want ce=1 %h/%h",
               tag, ce_scale_o & ce_offset_o, scale_o, offset_o, s, o);
    end
    finish_update(tag, 1, 0, en);
  endtask

  task automatic test_reset();
    logic en;
    rstn_i = 1'b0; enable_i = 1'b0; valid_i = 1'b0; gt_i = 1'b0; lt_i = 1'b0;
    man_load_i = 1'b0; man_scale_i = '0; man_offset_i = '0;
    #12;
    checks++;
    if (scale_o !== 17'h01000 || offset_o !== 16'h0 || ce_scale_o !== 1'b0 || ce_offset_o !== 1'b0 ||
        apply_o !== 1'b0 || update_o !== 1'b0 || dsp_en_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got=%h/%h ce=%b%b ap=%b up=%b en=%b want=01000/0000 all 0",
               scale_o, offset_o, ce_scale_o, ce_offset_o, apply_o, update_o, dsp_en_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b1;
    m_scale = 32'h1000;
    m_off   = 0;
    push_exp();
    finish_update("enable", 3, 2, en);
    checks++;
    if (en !== 1'b0) begin
      failures++;
      $display("FAIL dsp_en_at_first_apply got=%b want=0", en);
    end
    checks++;
    if (dsp_en_o !== 1'b1) begin
      failures++;
      $display("FAIL dsp_en_after_apply got=%b want=1", dsp_en_o);
    end
  endtask

  task automatic test_window_balanced();
    logic en;
    feed(16, 8, 8, 1'b0);
    model_window(8, 8);
    finish_update("balanced", 3, 2, en);
  endtask

  task automatic test_scale_ceiling();
    logic en;
    do_man_load("man_1fff8", 17'h1FFF8, 16'h0000);
    feed(16, 0, 0, 1'b0);
    model_window(0, 0);
    finish_update("ceil_first", 3, 2, en);
    feed(16, 0, 0, 1'b0);
    model_window(0, 0);
    finish_update("ceil_hold", 3, 2, en);
  endtask

  task automatic test_offset_gaps();
    logic en;
    feed(16, 6, 0, 1'b1);
    model_window(6, 0);
    finish_update("gt_gaps", 3, 2, en);
  endtask

  task automatic test_man_load_mid();
    logic en;
    feed(5, 5, 0, 1'b0);
    do_man_load("man_mid", 17'h00800, 16'h0100);
    feed(16, 0, 0, 1'b0);
    model_window(0, 0);
    finish_update("after_man", 3, 2, en);
  endtask

  task automatic test_clamps();
    logic en;
    do_man_load("man_floor", 17'h00105, 16'h8100);
    feed(16, 16, 0, 1'b0);
    model_window(16, 0);
    finish_update("floor_neg_clamp", 3, 2, en);
    do_man_load("man_pos", 17'h01000, 16'h7EF8);
    feed(16, 0, 16, 1'b0);
    model_window(0, 16);
    finish_update("pos_clamp", 3, 2, en);
  endtask

  task automatic test_enable_low_and_reset();
    logic en;
    bit   bad;
    feed(5, 5, 0, 1'b0);
    enable_i = 1'b0;
    valid_i  = 1'b1;
    gt_i     = 1'b1;
    bad      = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (ce_scale_o || ce_offset_o || apply_o || update_o ||
          scale_o !== 17'(m_scale) || offset_o !== 16'(m_off)) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL disabled_hold got=%h/%h ce=%b ap=%b want=%h/%h no pulses",
               scale_o, offset_o, ce_scale_o, apply_o, 17'(m_scale), 16'(m_off));
    end
    @(posedge clk_i); #1;
    valid_i  = 1'b0;
    gt_i     = 1'b0;
    enable_i = 1'b1;
    push_exp();
    finish_update("reenable", 3, 2, en);
    feed(16, 0, 0, 1'b0);
    model_window(0, 0);
    finish_update("counts_discarded", 3, 2, en);
    man_scale_i  = 17'h02000;
    man_offset_i = 16'h0040;
    man_load_i   = 1'b1;
    @(posedge clk_i); #1;
    man_load_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (ce_scale_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_load_ce got=%b want=1", ce_scale_o);
    end
    rstn_i = 1'b0;
    #1;
    checks++;
    if (scale_o !== 17'h01000 || offset_o !== 16'h0 || ce_scale_o !== 1'b0 || ce_offset_o !== 1'b0 ||
        apply_o !== 1'b0 || dsp_en_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h/%h ce=%b ap=%b en=%b want=01000/0000 0 0 0",
               scale_o, offset_o, ce_scale_o, apply_o, dsp_en_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (apply_o !== 1'b0 || update_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_partial_pulse got=%b/%b want=0/0", apply_o, update_o);
    end
  endtask

  initial begin
    test_reset();
    test_window_balanced();
    test_scale_ceiling();
    test_offset_gaps();
    test_man_load_mid();
    test_clamps();
    test_enable_low_and_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
